// File: rtl/snes_pkg.sv
// Shared types for the controller input path: owner encoding, dip modes, vector width.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package snes_pkg;

    localparam int SNES_VEC_W = 8;

    typedef enum logic [1:0] {
        NONE = 2'b00,
        KB   = 2'b01,
        IR   = 2'b10,
        BTN  = 2'b11
    } owner_t;

    localparam logic [1:0] DIP_AUTO = 2'b00;
    localparam logic [1:0] DIP_KB   = 2'b01;
    localparam logic [1:0] DIP_IR   = 2'b10;
    localparam logic [1:0] DIP_BTN  = 2'b11;

    // Rotation order used by round-robin arbitration: KB -> IR -> BTN -> KB.
    function automatic owner_t rr_next(input owner_t o);
        case (o)
            KB:      rr_next = IR;
            IR:      rr_next = BTN;
            default: rr_next = KB;
        endcase
    endfunction

endpackage

// File: rtl/load_sync_edge.sv
// Synchronises the asynchronous console latch and emits a one-cycle strobe on its rising edge.
// Latency: strobe is high SYNC_STAGES cycles after load rises.
// Backpressure: none; every synchronised rising edge produces exactly one strobe.
module load_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset_n,
    input  logic load,
    output logic strobe
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], load};
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign strobe = sync_q[SYNC_STAGES-1] & ~prev_q;

endmodule

// File: rtl/input_source_arbiter.sv
// Picks which decoder (kb/ir/btn) owns the SNES button vector and snapshots it on each console latch.
// Latency: grant 1 cycle after request; out_vec SYNC_STAGES+1 cycles after load rises. Macro ARB_ROUND_ROBIN_EN selects round-robin IDLE arbitration.
// Backpressure: none; sources are sampled every cycle and the encoder never stalls the snapshot.
module input_source_arbiter
    import snes_pkg::*;
#(
    parameter int HOLD_CYCLES = 50000,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [SNES_VEC_W-1:0] kb_vec,
    input  logic [SNES_VEC_W-1:0] ir_vec,
    input  logic [SNES_VEC_W-1:0] btn_vec,
    input  logic [1:0]            dip,
    input  logic                  load,
    output logic [SNES_VEC_W-1:0] out_vec,
    output logic [1:0]            grant,
    output logic                  latch_pulse
);

    localparam int              CNT_W    = $clog2(HOLD_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    owner_t                  state;
    owner_t                  pick;
    owner_t                  forced_own;
    logic [CNT_W-1:0]        hold_cnt;
    logic                    forced_q;
    logic [SNES_VEC_W-1:0]   sel_vec;
    logic                    load_stb;

    load_sync_edge #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_load_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .load    (load),
        .strobe  (load_stb)
    );

    // Driven from the registered owner, so a snapshot coinciding with a grant change takes the old owner.
    always_comb begin
        sel_vec = '0;
        case (state)
            KB:      sel_vec = kb_vec;
            IR:      sel_vec = ir_vec;
            BTN:     sel_vec = btn_vec;
            default: sel_vec = '0;
        endcase
    end

    always_comb begin
        forced_own = NONE;
        case (dip)
            DIP_KB:  forced_own = KB;
            DIP_IR:  forced_own = IR;
            DIP_BTN: forced_own = BTN;
            default: forced_own = NONE;
        endcase
    end

`ifdef ARB_ROUND_ROBIN_EN
    owner_t     last_q;
    owner_t     cand1;
    owner_t     cand2;
    owner_t     cand3;
    logic [3:0] src_act;

    always_comb begin
        src_act = {|btn_vec, |ir_vec, |kb_vec, 1'b0};
        cand1   = rr_next(last_q);
        cand2   = rr_next(cand1);
        cand3   = rr_next(cand2);
        pick    = NONE;
        if (src_act[cand1])
            pick = cand1;
        else if (src_act[cand2])
            pick = cand2;
        else if (src_act[cand3])
            pick = cand3;
    end

    // Starts at BTN so the first grant after reset prefers KB.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            last_q <= BTN;
        else if (state != NONE)
            last_q <= state;
    end
`else
    always_comb begin
        pick = NONE;
        if (|btn_vec)
            pick = BTN;
        else if (|kb_vec)
            pick = KB;
        else if (|ir_vec)
            pick = IR;
    end
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= NONE;
            hold_cnt <= '0;
            forced_q <= 1'b0;
        end else begin
            forced_q <= (dip != DIP_AUTO);
            if (dip != DIP_AUTO) begin
                state    <= forced_own;
                hold_cnt <= '0;
            end else if (forced_q) begin
                // Leaving a forced mode always passes through IDLE before auto arbitration.
                state    <= NONE;
                hold_cnt <= '0;
            end else if (state == NONE) begin
                state    <= pick;
                hold_cnt <= '0;
            end else if (sel_vec != '0) begin
                hold_cnt <= '0;
            end else if (hold_cnt == CNT_LAST) begin
                state    <= NONE;
                hold_cnt <= '0;
            end else if (hold_cnt != CNT_MAX) begin
                hold_cnt <= hold_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_vec     <= '0;
            latch_pulse <= 1'b0;
        end else begin
            latch_pulse <= load_stb;
            if (load_stb)
                out_vec <= sel_vec;
        end
    end

    assign grant = state;

endmodule

// File: tb/tb_input_source_arbiter.sv
// Randomised and directed check of input_source_arbiter against a cycle-level reference model.
module tb_input_source_arbiter;

    localparam int HOLD = 8;
    localparam int S    = 2;
    localparam int LD_H = S + 2;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [7:0] kb_vec, ir_vec, btn_vec;
    logic [1:0] dip;
    logic       load;
    logic [7:0] out_vec;
    logic [1:0] grant;
    logic       latch_pulse;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state
    int         m_owner;
    int         m_last;
    int         m_prev_dip;
    int         zero_run;
    logic [7:0] m_out;
    bit         m_pulse;
    bit         ld_hist [LD_H];

    input_source_arbiter #(
        .HOLD_CYCLES (HOLD),
        .SYNC_STAGES (S)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .kb_vec      (kb_vec),
        .ir_vec      (ir_vec),
        .btn_vec     (btn_vec),
        .dip         (dip),
        .load        (load),
        .out_vec     (out_vec),
        .grant       (grant),
        .latch_pulse (latch_pulse)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%h expected 0x%h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [7:0] vec_of(input int o);
        case (o)
            1:       return kb_vec;
            2:       return ir_vec;
            3:       return btn_vec;
            default: return 8'h00;
        endcase
    endfunction

    function automatic int choose();
`ifdef ARB_ROUND_ROBIN_EN
        for (int i = 1; i <= 3; i++) begin
            int cand;
            cand = ((m_last - 1 + i) % 3) + 1;
            if (vec_of(cand) != 8'h00) return cand;
        end
        return 0;
`else
        if (btn_vec != 8'h00) return 3;
        if (kb_vec != 8'h00) return 1;
        if (ir_vec != 8'h00) return 2;
        return 0;
`endif
    endfunction

    task automatic model_reset();
        m_owner    = 0;
        m_last     = 3;
        m_prev_dip = 0;
        zero_run   = 0;
        m_out      = 8'h00;
        m_pulse    = 1'b0;
        for (int i = 0; i < LD_H; i++) ld_hist[i] = 1'b0;
    endtask

    // One clock edge: load history gives the snapshot moment, ownership follows the hold/force rules.
    task automatic model_tick();
        for (int i = LD_H - 1; i > 0; i--) ld_hist[i] = ld_hist[i-1];
        ld_hist[0] = load;
        m_pulse = ld_hist[S] && !ld_hist[S+1];
        if (m_pulse) m_out = vec_of(m_owner);
        if (dip != 2'b00) begin
            m_owner  = int'(dip);
            zero_run = 0;
        end else if (m_prev_dip != 0) begin
            m_owner  = 0;
            zero_run = 0;
        end else if (m_owner == 0) begin
            m_owner  = choose();
            zero_run = 0;
        end else if (vec_of(m_owner) != 8'h00) begin
            zero_run = 0;
        end else begin
            zero_run++;
            if (zero_run >= HOLD) begin
                m_owner  = 0;
                zero_run = 0;
            end
        end
        if (m_owner != 0) m_last = m_owner;
        m_prev_dip = int'(dip);
    endtask

    task automatic step();
        @(posedge clk);
        if (!reset_n) model_reset();
        else model_tick();
        #1;
        chk("grant", {6'd0, grant}, 8'(m_owner));
        chk("out_vec", out_vec, m_out);
        chk("latch_pulse", {7'd0, latch_pulse}, {7'd0, m_pulse});
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic clear_owner_vec(input logic [1:0] g);
        case (g)
            2'b01:   kb_vec  = 8'h00;
            2'b10:   ir_vec  = 8'h00;
            2'b11:   btn_vec = 8'h00;
            default: ;
        endcase
    endtask

    logic [1:0] seq [4];

    initial begin
        reset_n = 1'b0;
        kb_vec  = 8'h00;
        ir_vec  = 8'h00;
        btn_vec = 8'h00;
        dip     = 2'b00;
        load    = 1'b0;
        model_reset();
        steps(2);
        reset_n = 1'b1;
        steps(3);

        // Priority: btn beats kb, then a load snapshot 3 cycles after load rises
        kb_vec  = 8'h10;
        btn_vec = 8'h01;
        step();
        chk("prio_grant", {6'd0, grant}, 8'h03);
        load = 1'b1;
        steps(3);
        chk("prio_out", out_vec, 8'h01);
        chk("prio_pulse", {7'd0, latch_pulse}, 8'h01);
        steps(4);
        load = 1'b0;
        steps(5);

        // Hold timeout with a re-press restarting the count
        btn_vec = 8'h00;
        kb_vec  = 8'h00;
        steps(HOLD + 2);
        kb_vec = 8'h10;
        steps(2);
        chk("hold_own", {6'd0, grant}, 8'h01);
        kb_vec = 8'h00;
        ir_vec = 8'h20;
        steps(4);
        kb_vec = 8'h10;
        step();
        kb_vec = 8'h00;
        steps(HOLD - 1);
        chk("hold_keep", {6'd0, grant}, 8'h01);
        step();
        chk("hold_idle", {6'd0, grant}, 8'h00);
        step();
        chk("hold_next", {6'd0, grant}, 8'h02);

        // Forced mode overrides priority, release to auto passes through IDLE
        dip     = 2'b10;
        btn_vec = 8'hFF;
        ir_vec  = 8'h04;
        step();
        chk("force_grant", {6'd0, grant}, 8'h02);
        load = 1'b1;
        steps(3);
        chk("force_out", out_vec, 8'h04);
        load = 1'b0;
        steps(3);
        dip = 2'b00;
        step();
        chk("unforce_idle", {6'd0, grant}, 8'h00);
        step();
        chk("unforce_btn", {6'd0, grant}, 8'h03);

        // Load edge coinciding with a grant change takes the old owner's vector
        load = 1'b1;
        steps(2);
        dip    = 2'b01;
        kb_vec = 8'h33;
        step();
        chk("coinc_grant", {6'd0, grant}, 8'h01);
        chk("coinc_out", out_vec, 8'hFF);
        steps(3);
        load = 1'b0;
        steps(4);
        dip = 2'b00;
        steps(2);

        // Asynchronous reset mid-ownership, load still high
        load = 1'b1;
        #3;
        reset_n = 1'b0;
        #1;
        model_reset();
        chk("arst_grant", {6'd0, grant}, 8'h00);
        chk("arst_out", out_vec, 8'h00);
        chk("arst_pulse", {7'd0, latch_pulse}, 8'h00);
        steps(2);
        kb_vec  = 8'h00;
        ir_vec  = 8'h00;
        btn_vec = 8'h00;
        load    = 1'b0;
        reset_n = 1'b1;
        steps(4);
        chk("post_rst_idle", {6'd0, grant}, 8'h00);

        // Repeated releases with every source active
`ifdef ARB_ROUND_ROBIN_EN
        seq[0] = 2'b01; seq[1] = 2'b10; seq[2] = 2'b11; seq[3] = 2'b01;
`else
        seq[0] = 2'b11; seq[1] = 2'b11; seq[2] = 2'b11; seq[3] = 2'b11;
`endif
        kb_vec  = 8'h01;
        ir_vec  = 8'h02;
        btn_vec = 8'h04;
        step();
        for (int r = 0; r < 4; r++) begin
            chk("rotate", {6'd0, grant}, {6'd0, seq[r]});
            clear_owner_vec(grant);
            steps(HOLD);
            kb_vec  = 8'h01;
            ir_vec  = 8'h02;
            btn_vec = 8'h04;
            step();
        end

        // Random traffic
        for (int c = 0; c < 4000; c++) begin
            if ($urandom_range(5) == 0) begin
                case ($urandom_range(2))
                    0: kb_vec  = ($urandom_range(1) == 0) ? 8'h00 : 8'($urandom);
                    1: ir_vec  = ($urandom_range(1) == 0) ? 8'h00 : 8'($urandom);
                    default: btn_vec = ($urandom_range(1) == 0) ? 8'h00 : 8'($urandom);
                endcase
            end
            if ($urandom_range(99) == 0)
                dip = ($urandom_range(9) < 7) ? 2'b00 : 2'($urandom_range(3));
            if ($urandom_range(4) == 0)
                load = ~load;
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/input_source_arbiter.md
Name: input_source_arbiter

Overview:
- Decides which controller source (keyboard, IR remote or button board) drives the SNES encoder's 8-bit button vector.
- Replaces the fixed dip-select mux with a hold-timed ownership FSM. Dip can still force any one source.
- Snapshots the selected vector on each console latch (load) edge, so the encoder shifts a stable word.
- Sits between the three decoders and snes_encoder.

Parameters:
- HOLD_CYCLES, 50000: idle clk cycles an owner keeps the grant after its vector goes to zero (50 ms at 1 MHz).
- SYNC_STAGES, 2: flip-flop depth of the load synchroniser (minimum 2).

Ports:
- clk  input  1  system clock
- reset_n  input  1  asynchronous active-low reset
- kb_vec  input  8  keyboard button vector, active-high
- ir_vec  input  8  IR button vector, active-high
- btn_vec  input  8  button-board vector, already inverted to active-high
- dip  input  2  mode: 00 auto, 01 force kb, 10 force ir, 11 force btn
- load  input  1  console latch, asynchronous to clk
- out_vec  output  8  latched vector to snes_encoder
- grant  output  2  current owner: 00 none, 01 kb, 10 ir, 11 btn
- latch_pulse  output  1  one-cycle strobe when out_vec updates

Behaviour:
- Reset (asynchronous, active-low): out_vec=0, grant=00, latch_pulse=0, FSM=IDLE, hold counter=0, synchroniser flops=0.
- FSM states: IDLE, OWN_KB, OWN_IR, OWN_BTN. grant encodes the state.
- Auto mode (dip=00):
  - IDLE: on the first cycle any vector is nonzero, grant goes to the highest-priority nonzero source (BTN > KB > IR). Transition takes 1 cycle. Counter loads 0.
  - OWN_x with vec_x nonzero: counter clears to 0. Other sources are ignored, even if nonzero.
  - OWN_x with vec_x zero: counter increments. When counter == HOLD_CYCLES-1, go to IDLE on the next edge.
  - Release with another source active: the next cycle moves IDLE→new owner. No direct owner-to-owner jump.
  - Counter is wide enough for HOLD_CYCLES and saturates; it never wraps.
- Forced modes (dip≠00):
  - FSM goes directly to the forced OWN state on the next edge, from any state.
  - The hold counter is ignored.
  - Ownership is kept while dip stays at that value.
- dip change:
  - To 00: FSM re-enters IDLE and arbitrates normally on the following cycle.
  - Between forced values: FSM switches directly.
  - dip is treated as quasi-static and is not synchronised.
- Selected vector: combinational from grant. It is 0 when grant=00.
- Load handling:
  - load passes through the SYNC_STAGES synchroniser, then a rising-edge detect.
  - On the detected edge: out_vec <= selected vector and latch_pulse=1 for exactly 1 cycle.
  - out_vec is held between edges.
  - Latency from load rising to out_vec valid: SYNC_STAGES+1 clk cycles.
- Simultaneous events:
  - Load edge in the same cycle as a grant change: the snapshot uses the pre-edge selected vector (registered grant).
  - Release and a new request in the same cycle: release wins; grant follows next cycle.
- Reset mid-operation: immediate return to reset values. A pending load edge is lost.

Optional Feature:
- Macro ARB_ROUND_ROBIN_EN.
- Defined: IDLE arbitration is round-robin. Priority starts at the source after the last owner (order KB→IR→BTN→KB). The last-owner register resets to BTN, so the first grant prefers KB.
- Undefined: fixed priority BTN > KB > IR, and no last-owner register exists.

Decomposition:
- Shared package snes_pkg holds:
  - owner_t enum (NONE=2'b00, KB=2'b01, IR=2'b10, BTN=2'b11).
  - mode constants for dip.
  - SNES_VEC_W=8.
- One natural sub-module: load_sync_edge. It holds the SYNC_STAGES synchroniser and rising-edge detect, and outputs a 1-cycle strobe.
- The FSM, counter and snapshot register stay in input_source_arbiter.

Test Plan:
- Reset: assert reset_n=0 mid-ownership → out_vec=0x00, grant=00, latch_pulse=0 immediately. After release, no grant until a vector is nonzero.
- Priority: dip=00, kb_vec=0x10 and btn_vec=0x01 in the same cycle → grant=11 next cycle. A load edge then gives out_vec=0x01 and a single latch_pulse, 3 cycles after load rises.
- Hold timeout: HOLD_CYCLES=8, OWN_KB, kb_vec→0 while ir_vec=0x20 → grant stays 01 for 8 cycles, then 00 for 1 cycle, then 10. A kb_vec re-press at cycle 5 keeps grant=01 and restarts the count.
- Forced mode: dip=10 with btn_vec=0xFF, ir_vec=0x04 → grant=10 next cycle. Load gives out_vec=0x04. dip→00 → IDLE, then grant=11.
- Load coincident with a grant change: snapshot equals the old owner's vector. Only one latch_pulse per load high period, and none on the load falling edge.
- ARB_ROUND_ROBIN_EN: kb, ir and btn all held nonzero with repeated release cycles → grant sequence 01, 10, 11, 01.
